// File: rtl/iob_ptfloat_mul.sv
// Iterative pt-float multiplier: radix-2 Booth, one multiplier bit per enabled cycle,
// followed by a one-cycle normalise/range-check stage. Operands and result are unpacked.
module iob_ptfloat_mul #(
  parameter int EXP_W = 9,
  parameter int MAN_W = 29
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             cke_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [EXP_W-1:0] exp_a_i,
  input  logic [MAN_W-1:0] man_a_i,
  input  logic [EXP_W-1:0] exp_b_i,
  input  logic [MAN_W-1:0] man_b_i,
  output logic [EXP_W-1:0] exp_o,
  output logic [MAN_W-1:0] man_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int CNT_W = $clog2(MAN_W) + 1;
  localparam int PW    = 2 * MAN_W;
  localparam int EW    = EXP_W + 2;
  localparam logic signed [EW-1:0] E_MAX = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] E_MIN = ~E_MAX;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [MAN_W-1:0]  man_a_q;
  logic [MAN_W-1:0]         mq_q;
  logic                     q1_q;
  logic signed [MAN_W:0]    acc_q;
  logic signed [EXP_W-1:0]  exp_a_q, exp_b_q;
  logic signed [EW-1:0]     e_q;

  logic signed [MAN_W:0]    a_ext, sum;
  logic [PW-1:0]            p;
  logic signed [EW-1:0]     e_n;
  logic [MAN_W-1:0]         m_n;
  logic [EXP_W-1:0]         res_exp;
  logic [MAN_W-1:0]         res_man;
  logic                     res_ovf, res_unf;

  // FSM: state register
  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i)    state_q <= IDLE;
    else if (cke_i) state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = MUL;
      MUL:  if (cnt_q == CNT_W'(MAN_W - 1)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == MUL) || (state_q == NORM);
    done_o = (state_q == DONE);
  end

  // Booth step on the current multiplier LSB pair; acc is one bit wider than the
  // multiplicand so subtracting the most negative mantissa cannot wrap.
  always_comb begin
    a_ext = {man_a_q[MAN_W-1], man_a_q};
    case ({mq_q[0], q1_q})
      2'b01:   sum = acc_q + a_ext;
      2'b10:   sum = acc_q - a_ext;
      default: sum = acc_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      cnt_q   <= '0;
      man_a_q <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      acc_q   <= '0;
      exp_a_q <= '0;
      exp_b_q <= '0;
      e_q     <= '0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: if (start_i) begin
          cnt_q   <= '0;
          man_a_q <= man_a_i;
          mq_q    <= man_b_i;
          q1_q    <= 1'b0;
          acc_q   <= '0;
          exp_a_q <= exp_a_i;
          exp_b_q <= exp_b_i;
        end
        MUL: begin
          cnt_q <= cnt_q + CNT_W'(1);
          acc_q <= {sum[MAN_W], sum[MAN_W:1]};
          mq_q  <= {sum[0], mq_q[MAN_W-1:1]};
          q1_q  <= mq_q[0];
          e_q   <= EW'(exp_a_q) + EW'(exp_b_q);
        end
        default: ;
      endcase
    end

  // Product is Q4 with MSB weight -8; it always fits in PW bits, so acc's top bit is redundant.
  assign p = {acc_q[MAN_W-1:0], mq_q};

  always_comb begin
    m_n = p[PW-3:MAN_W-2];
    e_n = e_q;
    if (p[PW-1:PW-3] == 3'b000 || p[PW-1:PW-3] == 3'b111) begin
      m_n = p[PW-3:MAN_W-2];
      e_n = e_q;
    end else if (p[PW-1] == p[PW-2]) begin
      m_n = p[PW-2:MAN_W-1];
      e_n = e_q + EW'(1);
    end else begin
      // only reachable from -2.0 * -2.0 = 4.0
      m_n = p[PW-1:MAN_W];
      e_n = e_q + EW'(2);
    end
  end

  always_comb begin
    res_exp = e_n[EXP_W-1:0];
    res_man = m_n;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (p == '0) begin
      res_exp = '0;
      res_man = '0;
    end else if (e_n > E_MAX) begin
      res_exp = E_MAX[EXP_W-1:0];
      res_man = p[PW-1] ? {1'b1, {(MAN_W-1){1'b0}}} : {1'b0, {(MAN_W-1){1'b1}}};
      res_ovf = 1'b1;
    end else if (e_n < E_MIN) begin
      res_exp = '0;
      res_man = '0;
      res_unf = 1'b1;
    end
  end

  // Results land at the NORM->DONE edge and hold until the next DONE.
  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      exp_o <= '0;
      man_o <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else if (cke_i && state_q == NORM) begin
      exp_o <= res_exp;
      man_o <= res_man;
      ovf_o <= res_ovf;
      unf_o <= res_unf;
    end

endmodule

// File: tb/tb_iob_ptfloat_mul.sv
// Scoreboard bench for iob_ptfloat_mul: directed operand pairs with hand-computed results.
module tb_iob_ptfloat_mul;
  localparam int EXP_W = 9;
  localparam int MAN_W = 29;

  logic             clk_i = 1'b0;
  logic             arst_i = 1'b0;
  logic             cke_i = 1'b1;
  logic             start_i = 1'b0;
  logic             busy_o, done_o, ovf_o, unf_o;
  logic [EXP_W-1:0] exp_a_i = '0, exp_b_i = '0, exp_o;
  logic [MAN_W-1:0] man_a_i = '0, man_b_i = '0, man_o;

  iob_ptfloat_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o),
    .exp_a_i(exp_a_i), .man_a_i(man_a_i), .exp_b_i(exp_b_i), .man_b_i(man_b_i),
    .exp_o(exp_o), .man_o(man_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             ovf;
    logic             unf;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done_o must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done_o=1 with no outstanding op (cycle %0d)", cyc);
      end else begin
        cur = sb.pop_front();
        chk("exp_o",   32'(exp_o), 32'(cur.e));
        chk("man_o",   32'(man_o), 32'(cur.m));
        chk("ovf_o",   32'(ovf_o), 32'(cur.ovf));
        chk("unf_o",   32'(unf_o), 32'(cur.unf));
        chk("latency", 32'(cyc),   32'(cur.cyc));
        chk("busy_at_done", 32'(busy_o), 32'd0);
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] ma,
                       input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb,
                       input logic [EXP_W-1:0] re, input logic [MAN_W-1:0] rm,
                       input logic rovf, input logic runf, input int lat, input bit push);
    exp_t x;
    exp_a_i = ea; man_a_i = ma; exp_b_i = eb; man_b_i = mb;
    start_i = 1'b1;
    x.e = re; x.m = rm; x.ovf = rovf; x.unf = runf; x.cyc = cyc + lat;
    if (push) sb.push_back(x);
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles, %0d op(s) outstanding", n, sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_exp"},  32'(exp_o),  32'd0);
    chk({tag, "_man"},  32'(man_o),  32'd0);
    chk({tag, "_ovf"},  32'(ovf_o),  32'd0);
    chk({tag, "_unf"},  32'(unf_o),  32'd0);
  endtask

  // Mantissa constants (Q2.27): 1.0=0x8000000, 1.5=0xC000000, -1.5=0x14000000, -2.0=0x10000000
  initial begin
    repeat (3) @(negedge clk_i);
    check_zero_outputs("reset");
    arst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // 1.0*2^3 * -1.5*2^-2 = -1.5*2^1
    issue(9'd3, 29'h8000000, -9'sd2, 29'h14000000, 9'd1, 29'h14000000, 0, 0, 31, 1);
    wait_idle();

    // 1.5*1.5 = 1.125*2^1; a second start mid-MUL with other operands must be ignored
    issue(9'd0, 29'hC000000, 9'd0, 29'hC000000, 9'd1, 29'h9000000, 0, 0, 31, 1);
    repeat (4) @(negedge clk_i);
    chk("busy_mid_op", 32'(busy_o), 32'd1);
    exp_a_i = 9'd50; man_a_i = 29'h10000000; exp_b_i = 9'd60; man_b_i = 29'h14000000;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk_i);

    // -2.0 * -2.0 = 4.0 -> 1.0*2^2
    issue(9'd0, 29'h10000000, 9'd0, 29'h10000000, 9'd2, 29'h8000000, 0, 0, 31, 1);
    wait_idle();
    // zero operand
    issue(9'd5, 29'h0, 9'd7, 29'h14000000, 9'd0, 29'h0, 0, 0, 31, 1);
    wait_idle();
    // overflow, positive and negative
    issue(9'd200, 29'h8000000, 9'd200, 29'h8000000, 9'h0FF, 29'hFFFFFFF, 1, 0, 31, 1);
    wait_idle();
    issue(9'd200, 29'h14000000, 9'd200, 29'h8000000, 9'h0FF, 29'h10000000, 1, 0, 31, 1);
    wait_idle();
    // underflow
    issue(-9'sd200, 29'h8000000, -9'sd200, 29'h8000000, 9'd0, 29'h0, 0, 1, 31, 1);
    wait_idle();
    // exponent range edges: E=255 fits, E=256 (via normalise) overflows, E=-256 fits
    issue(9'd200, 29'h8000000, 9'd55, 29'h8000000, 9'h0FF, 29'h8000000, 0, 0, 31, 1);
    wait_idle();
    issue(9'd200, 29'hC000000, 9'd55, 29'hC000000, 9'h0FF, 29'hFFFFFFF, 1, 0, 31, 1);
    wait_idle();
    issue(-9'sd128, 29'h8000000, -9'sd128, 29'h8000000, 9'h100, 29'h8000000, 0, 0, 31, 1);
    wait_idle();
    // truncation toward -inf on both signs
    issue(9'd0, 29'h8000001, 9'd0, 29'h8000001, 9'd0, 29'h8000002, 0, 0, 31, 1);
    wait_idle();
    issue(9'd0, 29'h17FFFFFF, 9'd0, 29'h8000001, 9'd0, 29'h17FFFFFD, 0, 0, 31, 1);
    wait_idle();

    // clock-enable stall of 4 cycles mid-MUL
    issue(9'd3, 29'h8000000, -9'sd2, 29'h14000000, 9'd1, 29'h14000000, 0, 0, 35, 1);
    repeat (10) @(negedge clk_i);
    cke_i = 1'b0;
    repeat (4) @(negedge clk_i);
    cke_i = 1'b1;
    wait_idle();

    // reset mid-operation: outputs clear at once, abandoned op never completes
    issue(9'd0, 29'hC000000, 9'd0, 29'hC000000, 9'd1, 29'h9000000, 0, 0, 31, 0);
    repeat (9) @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(negedge clk_i);
    arst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    issue(9'd0, 29'h10000000, 9'd0, 29'h10000000, 9'd2, 29'h8000000, 0, 0, 31, 1);
    wait_idle();
    repeat (4) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

endmodule
